inta_sequencer: RTL and testbench

- Interrupt-acknowledge sequencer for the 8259-style PIC, in 8086 two-pulse mode.
- Sits between the priority resolver and the cascading status handler.
- Raises INT to the CPU and tracks the two INTA pulses. On the first pulse it freezes the winning IR id: that id drives the cascade lines and sets the ISR. On the second pulse it places the vector on the data bus, unless a slave owns the cycle.

---
 rtl/inta_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_inta_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - 8086-mode two-pulse interrupt-acknowledge sequencer for an 8259-style PIC
//
// Raises INT when the priority resolver has a request. The sequencer then
// follows the two CPU INTA pulses. The first pulse freezes the winning IR id,
// or id 7 when no request is pending, and pulses isr_set. The second pulse
// drives the vector byte when this device owns the cycle.
//
// Optional feature macro: PIC_AUTO_EOI_EN
//   defined   : isr_clear pulses on the second INTA rise when aeoi_mode=1
//               and the sequence was not spurious
//   undefined : aeoi_mode is ignored and isr_clear is tied low
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   inta_neg                     CPU acknowledge strobe, active low, async to clk
//   irq_pending, irq_id          request present / winning IR from the resolver
//   vector_base                  ICW2 T7..T3
//   single_mode_flag, sp_neg     ICW1 SNGL, master(1)/slave(0) strap
//   slaves_connected_flag        ICW3 in master mode, bit n = slave on IRn
//   slave_active_interrupt_flag  cascade handler: this slave is addressed
//   aeoi_mode                    ICW4 AEOI (PIC_AUTO_EOI_EN builds only)
//   int_out                      INT to the CPU
//   interrupt_id                 latched acknowledged id
//   ack_active                   acknowledge in progress, gates cascade drive
//   isr_set, isr_clear           one-cycle ISR[interrupt_id] set / clear pulses
//   data_out, data_out_en        vector byte and data bus drive enable
module inta_sequencer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inta_neg,
   input  logic       irq_pending,
   input  logic [2:0] irq_id,
   input  logic [4:0] vector_base,
   input  logic       single_mode_flag,
   input  logic       sp_neg,
   input  logic [7:0] slaves_connected_flag,
   input  logic       slave_active_interrupt_flag,
   input  logic       aeoi_mode,
   output logic       int_out,
   output logic [2:0] interrupt_id,
   output logic       ack_active,
   output logic       isr_set,
   output logic       isr_clear,
   output logic [7:0] data_out,
   output logic       data_out_en
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      ACK1 = 3'd2,
      GAP  = 3'd3,
      ACK2 = 3'd4
   } state_t;

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("inta_sequencer: SYNC_STAGES must be at least 2");
      end
   endgenerate

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   inta_s, inta_d;
   logic                   fall, rise;
   logic                   own;
   logic                   spurious_q, spurious_nxt;
   logic [2:0]             id_nxt;
   logic                   isr_set_nxt, isr_clear_nxt;
   logic [7:0]             data_nxt;
   logic                   data_en_nxt;

   // The chain and the edge register reset high. A reset taken while
   // inta_neg is low therefore produces a fall only after the low level
   // propagates through the chain. Only IDLE sees that fall, and IDLE ignores it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         inta_d <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], inta_neg};
         inta_d <= inta_s;
      end
   end

   assign inta_s = sync_q[SYNC_STAGES-1];
   assign fall   = inta_d & ~inta_s;
   assign rise   = ~inta_d & inta_s;

   // This device owns the vector cycle in three cases. The first is single mode.
   // The second is a master whose acknowledged IR has no slave behind it.
   // The third is a slave that the cascade handler reports as addressed.
   assign own = single_mode_flag
              | (sp_neg & ~slaves_connected_flag[interrupt_id])
              | (~sp_neg & slave_active_interrupt_flag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         interrupt_id <= 3'd0;
         spurious_q   <= 1'b0;
         isr_set      <= 1'b0;
         isr_clear    <= 1'b0;
         data_out     <= 8'h00;
         data_out_en  <= 1'b0;
      end else begin
         state        <= state_nxt;
         interrupt_id <= id_nxt;
         spurious_q   <= spurious_nxt;
         isr_set      <= isr_set_nxt;
         isr_clear    <= isr_clear_nxt;
         data_out     <= data_nxt;
         data_out_en  <= data_en_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      id_nxt        = interrupt_id;
      spurious_nxt  = spurious_q;
      isr_set_nxt   = 1'b0;
      isr_clear_nxt = 1'b0;
      data_nxt      = data_out;
      data_en_nxt   = data_out_en;

      case (state)
         IDLE: begin
            if (irq_pending) begin
               state_nxt = REQ;
            end
         end

         // INT stays raised even if the request goes away. An acknowledge
         // that arrives with no request pending is answered with IR7 and
         // does not set the ISR.
         REQ: begin
            if (fall) begin
               state_nxt = ACK1;
               if (irq_pending) begin
                  id_nxt       = irq_id;
                  isr_set_nxt  = 1'b1;
                  spurious_nxt = 1'b0;
               end else begin
                  id_nxt       = 3'd7;
                  spurious_nxt = 1'b1;
               end
            end
         end

         ACK1: begin
            if (rise) begin
               state_nxt = GAP;
            end
         end

         GAP: begin
            if (fall) begin
               state_nxt = ACK2;
               if (own) begin
                  data_nxt    = {vector_base, interrupt_id};
                  data_en_nxt = 1'b1;
               end
            end
         end

         ACK2: begin
            if (rise) begin
               state_nxt   = IDLE;
               data_nxt    = 8'h00;
               data_en_nxt = 1'b0;
`ifdef PIC_AUTO_EOI_EN
               isr_clear_nxt = aeoi_mode & ~spurious_q;
`endif
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifndef PIC_AUTO_EOI_EN
   logic unused_aeoi;
   assign unused_aeoi = aeoi_mode ^ spurious_q;
`endif

   // These outputs decode the registered state. Reset therefore drops INT and
   // the cascade gate at once, without waiting for a clock edge.
   assign int_out    = (state == REQ);
   assign ack_active = (state == ACK1) || (state == GAP) || (state == ACK2);

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - scoreboard bench for inta_sequencer
module tb_inta_sequencer;

   logic       clk;
   logic       reset;
   logic       inta_neg;
   logic       irq_pending;
   logic [2:0] irq_id;
   logic [4:0] vector_base;
   logic       single_mode_flag;
   logic       sp_neg;
   logic [7:0] slaves_connected_flag;
   logic       slave_active_interrupt_flag;
   logic       aeoi_mode;
   logic       int_out;
   logic [2:0] interrupt_id;
   logic       ack_active;
   logic       isr_set;
   logic       isr_clear;
   logic [7:0] data_out;
   logic       data_out_en;

   inta_sequencer #(.SYNC_STAGES(2)) dut (
      .clk                         (clk),
      .reset                       (reset),
      .inta_neg                    (inta_neg),
      .irq_pending                 (irq_pending),
      .irq_id                      (irq_id),
      .vector_base                 (vector_base),
      .single_mode_flag            (single_mode_flag),
      .sp_neg                      (sp_neg),
      .slaves_connected_flag       (slaves_connected_flag),
      .slave_active_interrupt_flag (slave_active_interrupt_flag),
      .aeoi_mode                   (aeoi_mode),
      .int_out                     (int_out),
      .interrupt_id                (interrupt_id),
      .ack_active                  (ack_active),
      .isr_set                     (isr_set),
      .isr_clear                   (isr_clear),
      .data_out                    (data_out),
      .data_out_en                 (data_out_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] id;
      int         set_cnt;
      logic       en;
      logic [7:0] vec;
      int         clr_cnt;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   seq_seen = 0;
   int   seq_exp  = 0;

`ifdef PIC_AUTO_EOI_EN
   localparam int AEOI_CLR = 1;
`else
   localparam int AEOI_CLR = 0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: gathers one acknowledge sequence, from the rise of ack_active
   // to its fall, and compares it against the oldest scoreboard entry.
   logic       prev_ack = 1'b0;
   logic       prev_int = 1'b0;
   logic       a_int_before, a_int_during, a_id_changed, a_en;
   logic [2:0] a_id;
   logic [7:0] a_vec;
   int         a_set;

   always @(negedge clk) begin
      exp_t e;
      if (!prev_ack && ack_active) begin
         a_int_before = prev_int;
         a_int_during = 1'b0;
         a_id         = interrupt_id;
         a_id_changed = 1'b0;
         a_set        = 0;
         a_en         = 1'b0;
         a_vec        = 8'h00;
      end
      if (ack_active) begin
         if (int_out) a_int_during = 1'b1;
         if (interrupt_id != a_id) a_id_changed = 1'b1;
         if (isr_set) a_set++;
         if (data_out_en) begin
            a_en  = 1'b1;
            a_vec = data_out;
         end
      end
      if (prev_ack && !ack_active) begin
         seq_seen++;
         if (sb.size() == 0) begin
            chk("unexpected_sequence", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("int_before_ack", int'(a_int_before), 1);
            chk("int_during_ack", int'(a_int_during), 0);
            chk("interrupt_id", int'(a_id), int'(e.id));
            chk("id_stable", int'(a_id_changed), 0);
            chk("isr_set_count", a_set, e.set_cnt);
            chk("data_out_en", int'(a_en), int'(e.en));
            chk("vector", int'(a_vec), int'(e.vec));
            chk("isr_clear", int'(isr_clear), e.clr_cnt);
         end
      end
      prev_ack = ack_active;
      prev_int = int_out;
   end

   // One full acknowledge. irq_id is changed during the first pulse to show
   // that it is ignored. irq_pending drops during the second pulse, so the
   // sequencer ends in IDLE.
   task automatic run_seq(input logic [2:0] id, input logic spurious, input exp_t e);
      sb.push_back(e);
      seq_exp++;
      irq_id      = id;
      irq_pending = 1'b1;
      tick(4);
      if (spurious) begin
         irq_pending = 1'b0;
         tick(2);
      end
      inta_neg = 1'b0;
      tick(6);
      irq_id   = ~id;
      inta_neg = 1'b1;
      tick(6);
      inta_neg = 1'b0;
      tick(2);
      irq_pending = 1'b0;
      tick(4);
      inta_neg = 1'b1;
      tick(6);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic bad;
      reset                       = 1'b1;
      inta_neg                    = 1'b1;
      irq_pending                 = 1'b0;
      irq_id                      = 3'd0;
      vector_base                 = 5'b01000;
      single_mode_flag            = 1'b1;
      sp_neg                      = 1'b1;
      slaves_connected_flag       = 8'h00;
      slave_active_interrupt_flag = 1'b0;
      aeoi_mode                   = 1'b0;
      tick(3);
      chk("rst_int_out", int'(int_out), 0);
      chk("rst_ack_active", int'(ack_active), 0);
      chk("rst_data_out_en", int'(data_out_en), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_interrupt_id", int'(interrupt_id), 0);
      chk("rst_isr_set", int'(isr_set), 0);
      chk("rst_isr_clear", int'(isr_clear), 0);
      reset = 1'b0;
      tick(3);

      // single mode, base 01000, IR3 -> 0x43
      run_seq(3'd3, 1'b0, '{id: 3'd3, set_cnt: 1, en: 1'b1, vec: 8'h43, clr_cnt: 0});

      // master, slave on IR2: a slave owns the vector cycle
      single_mode_flag      = 1'b0;
      sp_neg                = 1'b1;
      slaves_connected_flag = 8'h04;
      run_seq(3'd2, 1'b0, '{id: 3'd2, set_cnt: 1, en: 1'b0, vec: 8'h00, clr_cnt: 0});
      // master, IR5 has no slave: the master drives {01000,101}
      run_seq(3'd5, 1'b0, '{id: 3'd5, set_cnt: 1, en: 1'b1, vec: 8'h45, clr_cnt: 0});

      // slave addressed / not addressed, base 10101, IR6
      sp_neg                      = 1'b0;
      vector_base                 = 5'b10101;
      slave_active_interrupt_flag = 1'b1;
      run_seq(3'd6, 1'b0, '{id: 3'd6, set_cnt: 1, en: 1'b1, vec: 8'hAE, clr_cnt: 0});
      slave_active_interrupt_flag = 1'b0;
      run_seq(3'd6, 1'b0, '{id: 3'd6, set_cnt: 1, en: 1'b0, vec: 8'h00, clr_cnt: 0});

      // spurious: request withdrawn before the first fall -> IR7, no set/clear
      single_mode_flag = 1'b1;
      vector_base      = 5'b01000;
      aeoi_mode        = 1'b1;
      run_seq(3'd2, 1'b1, '{id: 3'd7, set_cnt: 0, en: 1'b1, vec: 8'h47, clr_cnt: 0});

      // auto-EOI, base 00010, IR5 -> 0x15
      vector_base = 5'b00010;
      run_seq(3'd5, 1'b0, '{id: 3'd5, set_cnt: 1, en: 1'b1, vec: 8'h15, clr_cnt: AEOI_CLR});
      aeoi_mode = 1'b0;

      // reset in the middle of ACK2 while the bus is driven
      vector_base = 5'b01000;
      sb.push_back('{id: 3'd1, set_cnt: 1, en: 1'b1, vec: 8'h41, clr_cnt: 0});
      seq_exp++;
      irq_id      = 3'd1;
      irq_pending = 1'b1;
      tick(4);
      inta_neg = 1'b0;
      tick(6);
      inta_neg = 1'b1;
      tick(6);
      inta_neg = 1'b0;
      tick(2);
      irq_pending = 1'b0;
      tick(6);
      chk("pre_reset_data_out_en", int'(data_out_en), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_data_out_en", int'(data_out_en), 0);
      chk("async_rst_int_out", int'(int_out), 0);
      chk("async_rst_ack_active", int'(ack_active), 0);
      chk("async_rst_data_out", int'(data_out), 0);
      tick(2);
      reset = 1'b0;
      // inta_neg is still low: its fall and a further full pulse arrive in IDLE
      bad = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i == 8)  inta_neg = 1'b1;
         if (i == 16) inta_neg = 1'b0;
         if (i == 24) inta_neg = 1'b1;
         tick(1);
         if (int_out || ack_active || isr_set || data_out_en) bad = 1'b1;
      end
      chk("idle_fall_ignored", int'(bad), 0);

      for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
      chk("scoreboard_drained", sb.size(), 0);
      chk("sequence_count", seq_seen, seq_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
